// File: rtl/seq_reco.sv
// -----------------------------------------------------------------------------
// seq_reco -- sequential recorrelator for unipolar stochastic bitstreams.
//
// Re-times the bits of two streams so that the output pair is pushed toward
// maximal positive correlation (SCC -> +1). A 1 that arrives on one stream
// without a partner is held as a "credit" in a small signed saturating
// counter. It is released later, paired with a lone 1 on the other stream.
// Held credits are not flushed at end of stream; they are discarded by reset.
//
// Parameters:
//   DEPTH     maximum number of unmatched 1s held for one stream (>= 1)
//
// Ports:
//   clk       input   system clock, rising-edge active
//   rst_n     input   synchronous reset, active-low
//   x         input   stream X bit for the current cycle
//   y         input   stream Y bit for the current cycle
//   x_reco_r  output  registered recorrelated X bit (one edge latency)
//   y_reco_r  output  registered recorrelated Y bit (one edge latency)
// -----------------------------------------------------------------------------
module seq_reco #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic x,
   input  logic y,
   output logic x_reco_r,
   output logic y_reco_r
);

   // Counter spans -DEPTH..+DEPTH: magnitude bits plus a sign bit.
   localparam int CW = $clog2(DEPTH + 1) + 1;

   localparam logic signed [CW-1:0] C_MAX  = CW'(DEPTH);
   localparam logic signed [CW-1:0] C_MIN  = -C_MAX;
   localparam logic signed [CW-1:0] C_ONE  = CW'(1);

   // r_c > 0 : r_c X-ones held;  r_c < 0 : |r_c| Y-ones held.
   logic signed [CW-1:0] r_c;
   logic signed [CW-1:0] w_c_next;
   logic                 w_ox;
   logic                 w_oy;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_c_next = r_c;
      w_ox     = x;   // (1,1) and (0,0) pass straight through
      w_oy     = y;

      unique case ({x, y})
         2'b10: begin
            if (r_c[CW-1]) begin
               // A Y-one is held: pair it with this X-one.
               w_ox     = 1'b1;
               w_oy     = 1'b1;
               w_c_next = r_c + C_ONE;
            end else if (r_c != C_MAX) begin
               // Room left: hold the X-one for a later Y-one.
               w_ox     = 1'b0;
               w_oy     = 1'b0;
               w_c_next = r_c + C_ONE;
            end
            // Saturated: default pass-through of (1,0), counter unchanged.
         end
         2'b01: begin
            if (!r_c[CW-1] && (r_c != '0)) begin
               // An X-one is held: pair it with this Y-one.
               w_ox     = 1'b1;
               w_oy     = 1'b1;
               w_c_next = r_c - C_ONE;
            end else if (r_c != C_MIN) begin
               // Room left: hold the Y-one for a later X-one.
               w_ox     = 1'b0;
               w_oy     = 1'b0;
               w_c_next = r_c - C_ONE;
            end
            // Saturated: default pass-through of (0,1), counter unchanged.
         end
         default: begin
            // (0,0) and (1,1) keep the defaults.
         end
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_c      <= '0;
         x_reco_r <= 1'b0;
         y_reco_r <= 1'b0;
      end else begin
         r_c      <= w_c_next;
         x_reco_r <= w_ox;
         y_reco_r <= w_oy;
      end
   end

endmodule

// File: tb/tb_seq_reco.sv
// -----------------------------------------------------------------------------
// tb_seq_reco -- self-checking bench for seq_reco (DEPTH = 1).
//
// The stimulus process drives one (x,y) pair per cycle on the falling edge
// and pushes the expected registered output into a scoreboard queue. A
// separate monitor pops one entry 1 ns after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_seq_reco;

   localparam int DEPTH = 1;

   logic clk;
   logic rst_n;
   logic x;
   logic y;
   logic x_reco_r;
   logic y_reco_r;

   seq_reco #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .x        (x),
      .y        (y),
      .x_reco_r (x_reco_r),
      .y_reco_r (y_reco_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] exp;
      int         grp;
      int         idx;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   string     grp_name[8];

   int n_checks = 0;
   int n_pass   = 0;
   int vec_idx  = 0;
   int out_x_cnt = 0;
   int out_y_cnt = 0;

   // Reference state for the random streams.
   int m_c = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // One cycle: drive inputs on the falling edge, queue the expected output.
   task automatic apply(input logic xi, input logic yi, input logic rn,
                        input logic [1:0] exp, input int grp);
      sb_entry_t e;
      @(negedge clk);
      x     = xi;
      y     = yi;
      rst_n = rn;
      e.exp = exp;
      e.grp = grp;
      e.idx = vec_idx;
      vec_idx++;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("drain", sb_q.size(), 0);
   endtask

   // Reference model of the recorrelation rules.
   task automatic model_step(input logic xi, input logic yi, output logic [1:0] o);
      o = {xi, yi};
      if (xi && !yi) begin
         if (m_c < 0)          begin o = 2'b11; m_c = m_c + 1; end
         else if (m_c < DEPTH) begin o = 2'b00; m_c = m_c + 1; end
      end else if (!xi && yi) begin
         if (m_c > 0)           begin o = 2'b11; m_c = m_c - 1; end
         else if (m_c > -DEPTH) begin o = 2'b00; m_c = m_c - 1; end
      end
   endtask

   task automatic do_reset(input int grp);
      apply(1'b0, 1'b0, 1'b0, 2'b00, grp);
      m_c = 0;
   endtask

   task automatic run_random(input int density, input int grp);
      logic       xi;
      logic       yi;
      logic [1:0] o;
      int         in_x;
      int         in_y;
      do_reset(grp);
      drain();
      out_x_cnt = 0;
      out_y_cnt = 0;
      in_x = 0;
      in_y = 0;
      for (int i = 0; i < 256; i++) begin
         xi = ($urandom_range(99) < density);
         yi = ($urandom_range(99) < density);
         in_x += int'(xi);
         in_y += int'(yi);
         model_step(xi, yi, o);
         apply(xi, yi, 1'b1, o, grp);
      end
      drain();
      // Ones are preserved except for credits still held at the end.
      check($sformatf("%s x ones", grp_name[grp]), out_x_cnt,
            in_x - ((m_c > 0) ? m_c : 0));
      check($sformatf("%s y ones", grp_name[grp]), out_y_cnt,
            in_y - ((m_c < 0) ? -m_c : 0));
   endtask

   // Monitor: one output pair per cycle, compared against the scoreboard.
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check($sformatf("%s #%0d out", grp_name[e.grp], e.idx),
                  int'({x_reco_r, y_reco_r}), int'(e.exp));
            out_x_cnt += int'(x_reco_r);
            out_y_cnt += int'(y_reco_r);
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      grp_name[0] = "reset";
      grp_name[1] = "passthru";
      grp_name[2] = "defer_y";
      grp_name[3] = "release_y";
      grp_name[4] = "defer_x";
      grp_name[5] = "midreset";
      grp_name[6] = "random";
      grp_name[7] = "unused";

      rst_n = 1'b0;
      x     = 1'b0;
      y     = 1'b0;

      // Reset state, with inputs active during reset.
      apply(1'b1, 1'b1, 1'b0, 2'b00, 0);
      apply(1'b1, 0,    1'b0, 2'b00, 0);

      // Pass-through.
      apply(1, 1, 1, 2'b11, 1);
      apply(0, 0, 1, 2'b00, 1);
      apply(1, 1, 1, 2'b11, 1);

      // Deferred Y then saturation.
      do_reset(2);
      apply(1, 1, 1, 2'b11, 2);
      apply(0, 1, 1, 2'b00, 2);
      apply(0, 1, 1, 2'b01, 2);
      apply(1, 1, 1, 2'b11, 2);
      apply(0, 1, 1, 2'b01, 2);

      // Release a held Y credit.
      do_reset(3);
      apply(0, 1, 1, 2'b00, 3);
      apply(1, 0, 1, 2'b11, 3);

      // Deferred X with saturation and release.
      do_reset(4);
      apply(1, 1, 1, 2'b11, 4);
      apply(1, 0, 1, 2'b00, 4);
      apply(1, 1, 1, 2'b11, 4);
      apply(1, 0, 1, 2'b10, 4);
      apply(0, 1, 1, 2'b11, 4);
      apply(1, 0, 1, 2'b00, 4);
      apply(1, 0, 1, 2'b10, 4);
      apply(0, 1, 1, 2'b11, 4);
      apply(0, 1, 1, 2'b00, 4);
      apply(0, 1, 1, 2'b01, 4);

      // Synchronous reset mid-stream discards the held Y credit.
      do_reset(5);
      apply(0, 1, 1, 2'b00, 5);   // c = -1
      apply(1, 1, 0, 2'b00, 5);   // reset edge: outputs 0,0, c = 0
      apply(1, 0, 1, 2'b00, 5);   // credit gone: X-one held, c = +1
      apply(0, 1, 1, 2'b11, 5);   // held X-one released, c = 0
      apply(0, 1, 1, 2'b00, 5);   // c = -1 again
      drain();

      // Long random streams at several densities.
      run_random(25, 6);
      run_random(50, 6);
      run_random(80, 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
